// File: rtl/c2f_pkg.sv
// Shared types, widths and reference arithmetic for the shared Celsius-to-Fahrenheit controller.
package c2f_pkg;

    localparam int unsigned CEL_W    = 4;
    localparam int unsigned FAH_W    = 32;
    localparam int unsigned F_OFFSET = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } c2f_state_e;

    // Expected converter output: celsius*9/5 + 32 with truncating division.
    function automatic logic [FAH_W-1:0] c2f_ref(input logic [CEL_W-1:0] celsius);
        return (FAH_W'(celsius) * FAH_W'(9)) / FAH_W'(5) + FAH_W'(F_OFFSET);
    endfunction

endpackage

// File: rtl/c2f_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module c2f_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_req
);

    logic [ID_W-1:0] k;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!any_req && req[k]) begin
                grant[k] = 1'b1;
                idx      = k;
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cel_2_fah.sv
// Combinational Celsius-to-Fahrenheit converter shared by all requesters.
module cel_2_fah
    import c2f_pkg::*;
(
    input  logic [CEL_W-1:0] celsius,
    output logic [FAH_W-1:0] fahren
);

    assign fahren = (FAH_W'(celsius) * FAH_W'(9)) / FAH_W'(5) + FAH_W'(F_OFFSET);

endmodule

// File: rtl/c2f_share_ctrl.sv
// Round-robin sharing of one cel_2_fah converter among NUM_REQ requesters.
// Optional completed-conversion counter enabled by C2F_SHARE_STATS_EN.
module c2f_share_ctrl
    import c2f_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CONV_CYCLES = 1,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CEL_W-1:0] req_celsius,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [FAH_W-1:0]         rsp_fahren,
    output logic                     busy,
    output logic [15:0]              conv_count
);

    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    c2f_state_e         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    lat_id;
    logic [CEL_W-1:0]   lat_cel;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_req;
    logic [CEL_W-1:0]   gnt_cel;
    logic [FAH_W-1:0]   fahren;

    c2f_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .idx     (gnt_idx),
        .any_req (any_req)
    );

    // Converter only ever sees the operand captured on the grant cycle.
    cel_2_fah u_conv (
        .celsius (lat_cel),
        .fahren  (fahren)
    );

    always_comb begin
        gnt_cel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                gnt_cel = req_celsius[i*CEL_W +: CEL_W];
            end
        end
    end

    // Grant pulse is combinational and suppressed while reset is asserted.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            lat_cel    <= '0;
            lat_id     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_fahren <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_cel <= gnt_cel;
                        lat_id  <= gnt_idx;
                        rr_ptr  <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                        cnt     <= CNT_W'(CONV_CYCLES - 1);
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        rsp_fahren <= fahren;
                        rsp_id     <= lat_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef C2F_SHARE_STATS_EN
    logic [15:0] conv_cnt;

    // Saturating count of accepted responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_cnt <= '0;
        end else if (rsp_valid && rsp_ready && conv_cnt != 16'hFFFF) begin
            conv_cnt <= conv_cnt + 16'd1;
        end
    end

    assign conv_count = conv_cnt;
`else
    assign conv_count = 16'd0;
`endif

endmodule

// File: tb/tb_c2f_share_ctrl.sv
// Self-checking bench for c2f_share_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_c2f_share_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with CONV_CYCLES=1
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_celsius;
    logic        rsp_ready;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_fahren;
    logic        busy;
    logic [15:0] conv_count;

    // Instance with CONV_CYCLES=4
    logic        rst4_n;
    logic [3:0]  req_valid4;
    logic [15:0] req_celsius4;
    logic        rsp_ready4;
    logic [3:0]  req_ready4;
    logic        rsp_valid4;
    logic [1:0]  rsp_id4;
    logic [31:0] rsp_fahren4;
    logic        busy4;
    logic [15:0] conv_count4;

    int n_cmp = 0;
    int n_err = 0;

    c2f_share_ctrl #(.NUM_REQ(4), .CONV_CYCLES(1), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_celsius(req_celsius),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_fahren(rsp_fahren), .busy(busy), .conv_count(conv_count)
    );

    c2f_share_ctrl #(.NUM_REQ(4), .CONV_CYCLES(4), .ID_W(2)) dut4 (
        .clk(clk), .rst_n(rst4_n), .req_valid(req_valid4), .req_celsius(req_celsius4),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_id(rsp_id4), .rsp_fahren(rsp_fahren4), .busy(busy4), .conv_count(conv_count4)
    );

    function automatic int unsigned ref_f(input int unsigned c);
        return (c * 9) / 5 + 32;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'hF; req_celsius = 16'h1234; rsp_ready = 1'b1;
        rst4_n = 1'b0; req_valid4 = '0; req_celsius4 = '0; rsp_ready4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_fahren !== 32'd0) begin n_err++; $display("FAIL reset_rsp_fahren got %0d want 0", rsp_fahren); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (conv_count !== 16'd0) begin n_err++; $display("FAIL reset_conv_count got %0d want 0", conv_count); end
        req_valid = '0;
        rst_n = 1'b1;
        rst4_n = 1'b1;
    endtask

    task automatic test_single(input int id, input int cel);
        @(negedge clk);
        req_valid = 4'(1 << id); req_celsius = 16'(cel << (4 * id)); rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'(1 << id)) begin n_err++; $display("FAIL single_grant id=%0d got %b want %b", id, req_ready, 4'(1 << id)); end
        @(negedge clk);
        req_valid = '0; req_celsius = 16'($urandom);
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_settle got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'(id)) begin n_err++; $display("FAIL single_rsp_id got %0d want %0d", rsp_id, id); end
        n_cmp++; if (rsp_fahren !== 32'(ref_f(cel))) begin n_err++; $display("FAIL single_fahren cel=%0d got %0d want %0d", cel, rsp_fahren, ref_f(cel)); end
        @(negedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_return_idle got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        @(negedge clk);
        req_valid = 4'hF; req_celsius = 16'hFA50; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int  ex_id;
            bit  got;
            bit  seen;
            ex_id = k % 4;
            got = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                #1;
                n_cmp++; if ($countones(req_ready) > 1) begin n_err++; $display("FAIL rr_onehot got %b want at most one bit", req_ready); end
                if (req_ready != 4'b0) begin
                    got = 1'b1;
                    n_cmp++; if (req_ready !== 4'(1 << ex_id)) begin n_err++; $display("FAIL rr_order grant#%0d got %b want %b", k, req_ready, 4'(1 << ex_id)); end
                end
                @(negedge clk);
            end
            if (!got) begin n_cmp++; n_err++; $display("FAIL rr_grant_timeout grant#%0d got none want %0d", k, ex_id); end
            for (int c = 0; c < 10 && !seen; c++) begin
                #1;
                if (rsp_valid === 1'b1) begin
                    seen = 1'b1;
                    n_cmp++; if (rsp_id !== 2'(ex_id)) begin n_err++; $display("FAIL rr_rsp_id got %0d want %0d", rsp_id, ex_id); end
                    n_cmp++; if (rsp_fahren !== 32'(ref_f(5 * ex_id))) begin n_err++; $display("FAIL rr_fahren got %0d want %0d", rsp_fahren, ref_f(5 * ex_id)); end
                end
                @(negedge clk);
            end
            if (!seen) begin n_cmp++; n_err++; $display("FAIL rr_rsp_timeout grant#%0d got none want id %0d", k, ex_id); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 4'b0010; req_celsius = 16'h0070; rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'hF;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin n_cmp++; n_err++; $display("FAIL bp_rsp_timeout got none want rsp_valid"); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold c=%0d got %b want 1", c, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_id_hold c=%0d got %0d want 1", c, rsp_id); end
            n_cmp++; if (rsp_fahren !== 32'd44) begin n_err++; $display("FAIL bp_fahren_hold c=%0d got %0d want 44", c, rsp_fahren); end
            n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_no_grant c=%0d got %b want 0000", c, req_ready); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy c=%0d got %b want 1", c, busy); end
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL bp_handshake_grant got %b want 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid4 = 4'b0001; req_celsius4 = 16'h0003; rsp_ready4 = 1'b1;
        #1;
        n_cmp++; if (req_ready4 !== 4'b0001) begin n_err++; $display("FAIL mid_grant got %b want 0001", req_ready4); end
        @(negedge clk);
        req_valid4 = '0;
        #1;
        n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy4); end
        @(negedge clk);
        rst4_n = 1'b0; req_valid4 = 4'b0101; req_celsius4 = 16'h0609;
        @(negedge clk);
        #1;
        n_cmp++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL mid_busy_clear got %b want 0", busy4); end
        n_cmp++; if (req_ready4 !== 4'b0) begin n_err++; $display("FAIL mid_ready_in_reset got %b want 0000", req_ready4); end
        @(negedge clk);
        rst4_n = 1'b1;
        #1;
        n_cmp++; if (req_ready4 !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_reset got %b want 0001", req_ready4); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid4 = '0; req_celsius4 = 16'($urandom);
            #1;
            n_cmp++; if (rsp_valid4 !== (k == 5)) begin n_err++; $display("FAIL mid_latency cycle=%0d got %b want %b", k, rsp_valid4, (k == 5)); end
        end
        n_cmp++; if (rsp_id4 !== 2'd0) begin n_err++; $display("FAIL mid_rsp_id got %0d want 0", rsp_id4); end
        n_cmp++; if (rsp_fahren4 !== 32'(ref_f(9))) begin n_err++; $display("FAIL mid_fahren got %0d want %0d", rsp_fahren4, ref_f(9)); end
    endtask

    task automatic test_conv_count;
        int unsigned exp_cnt;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_celsius = 16'($urandom); rsp_ready = 1'b1;
            @(negedge clk);
            req_valid = '0;
            repeat (2) @(negedge clk);
        end
        #1;
`ifdef C2F_SHARE_STATS_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        n_cmp++; if (conv_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL conv_count got %0d want %0d", conv_count, exp_cnt); end
    endtask

    task automatic test_random;
        int          ptr = 0;
        int          cd = 0;
        bit          have = 1'b0;
        int          pid = 0;
        int unsigned pf = 0;
        int          hs = 0;
        int          g;
        bit          idle;
        logic [3:0]  rv;
        logic [15:0] rc;
        logic        rdy;
        logic [3:0]  exp_rr;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rv = 4'($urandom); rc = 16'($urandom); rdy = ($urandom % 3) != 0;
            req_valid = rv; req_celsius = rc; rsp_ready = rdy;
            #1;
            idle = (cd == 0) && !have;
            g = -1;
            if (idle) begin
                for (int i = 0; i < 4; i++) begin
                    if (g < 0 && rv[(ptr + i) % 4]) g = (ptr + i) % 4;
                end
            end
            exp_rr = (g >= 0) ? 4'(1 << g) : 4'b0;
            n_cmp++; if (req_ready !== exp_rr) begin n_err++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, req_ready, exp_rr); end
            n_cmp++; if (rsp_valid !== have) begin n_err++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, rsp_valid, have); end
            n_cmp++; if (busy !== !idle) begin n_err++; $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, !idle); end
            if (have) begin
                n_cmp++; if (rsp_id !== 2'(pid) || rsp_fahren !== 32'(pf)) begin
                    n_err++; $display("FAIL rand_rsp cyc=%0d got id=%0d f=%0d want id=%0d f=%0d", cyc, rsp_id, rsp_fahren, pid, pf);
                end
            end
            if (g >= 0) begin
                cd = 1; pid = g; pf = ref_f(int'(rc[4*g +: 4])); ptr = (g + 1) % 4;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) have = 1'b1;
            end else if (have && rdy) begin
                have = 1'b0;
                hs++;
            end
        end
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b0;
        #1;
`ifndef C2F_SHARE_STATS_EN
        hs = 0;
`endif
        n_cmp++; if (conv_count !== 16'(hs)) begin n_err++; $display("FAIL rand_conv_count got %0d want %0d", conv_count, hs); end
    endtask

    initial begin
        test_reset();
        test_single(0, 10);
        test_single(1, 1);
        test_single(2, 7);
        test_single(3, 15);
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_conv_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
